// File: rtl/regfile_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer that drives an external 4x32 register file.
// One instruction in flight at a time; results commit on the WB->IDLE edge.
module regfile_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [1:0]       readReg1,
    output logic [1:0]       readReg2,
    input  logic [31:0]      ReadData1,
    input  logic [31:0]      ReadData2,
    output logic [1:0]       WriteReg,
    output logic [31:0]      WriteData,
    output logic             RegWrite,
    output logic             busy,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t             state_q, state_d;
    logic [15:0]        instr_q, instr_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        result_q, result_d;
    logic [1:0]         rr1_q, rr1_d;
    logic [1:0]         rr2_q, rr2_d;
    logic               ill_q, ill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         op;
    logic               op_writes;
    logic               op_illegal;
    logic [31:0]        alu_res;

    assign op         = instr_q[15:12];
    assign op_writes  = (op >= 4'd1) && (op <= 4'd6);
    assign op_illegal = (op >= 4'd7);

    always_comb begin
        alu_res = 32'd0;
        case (op)
            4'd1:    alu_res = a_q + b_q;
            4'd2:    alu_res = a_q - b_q;
            4'd3:    alu_res = a_q & b_q;
            4'd4:    alu_res = a_q | b_q;
            4'd5:    alu_res = {24'd0, instr_q[7:0]};
            4'd6:    alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rr1_d    = rr1_q;
        rr2_d    = rr2_q;
        ill_d    = ill_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    rr1_d   = instr[9:8];
                    rr2_d   = instr[7:6];
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = ReadData1;
                b_d     = ReadData2;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_res;
                if (op_illegal) begin
                    ill_d = 1'b1;
                end
                state_d = WB;
            end
            WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over any handshake presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= 16'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            rr1_q    <= 2'd0;
            rr2_q    <= 2'd0;
            ill_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rr1_q    <= rr1_d;
            rr2_q    <= rr2_d;
            ill_q    <= ill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instr_ready   = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign readReg1      = rr1_q;
    assign readReg2      = rr2_q;
    assign WriteReg      = instr_q[11:10];
    assign WriteData     = result_q;
    // Gated by reset directly so an abort during WB never reaches the register file.
    assign RegWrite      = (state_q == WB) && !reset && op_writes;
    assign illegal_op    = ill_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: directed table, back-to-back and reset corner sequences,
// then random instructions checked against a plain-arithmetic reference model.
module tb_regfile_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             instr_valid;
    logic [15:0]      instr;
    logic             instr_ready;
    logic [1:0]       readReg1, readReg2;
    logic [31:0]      ReadData1, ReadData2;
    logic [1:0]       WriteReg;
    logic [31:0]      WriteData;
    logic             RegWrite;
    logic             busy;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_count;

    regfile_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .readReg1(readReg1), .readReg2(readReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteReg(WriteReg),
        .WriteData(WriteData), .RegWrite(RegWrite), .busy(busy),
        .illegal_op(illegal_op), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file (cleared on reset so the model can follow it).
    logic [31:0] rf [4];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= 32'd0;
        end else if (RegWrite) begin
            rf[WriteReg] <= WriteData;
        end
    end
    assign ReadData1 = rf[readReg1];
    assign ReadData2 = rf[readReg2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0]      model_rf [4];
    logic             model_ill;
    logic [CNT_W-1:0] model_cnt;
    int               hs_cyc_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [7:0] imm);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return {24'd0, imm};
            4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_rf[i] = 32'd0;
        model_ill = 1'b0;
        model_cnt = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, instr_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"}, RegWrite, 0);
        check({tag, "_wr"}, WriteReg, 0);
        check({tag, "_wd"}, WriteData, 0);
        check({tag, "_rr1"}, readReg1, 0);
        check({tag, "_rr2"}, readReg2, 0);
        check({tag, "_ill"}, illegal_op, 0);
        check({tag, "_cnt"}, retired_count, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Starts and ends just after a falling edge; one full instruction with per-state checks.
    task automatic do_instr(input logic [15:0] w, input bit hold, input logic [15:0] nxt,
                            output logic we_a, output logic [1:0] wr_a, output logic [31:0] wd_a);
        int n;
        logic [3:0]  op;
        logic [1:0]  rd, rs, rt;
        logic        exp_we;
        logic [31:0] exp_wd;
        op = w[15:12]; rd = w[11:10]; rs = w[9:8]; rt = w[7:6];
        exp_we = (op >= 4'd1) && (op <= 4'd6);
        exp_wd = model_result(op, model_rf[rs], model_rf[rt], w[7:0]);
        we_a = 1'b0; wr_a = 2'd0; wd_a = 32'd0;
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check("handshake_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        hs_cyc_last = cyc;
        @(negedge clk);
        instr_valid = hold;
        instr = hold ? nxt : 16'($urandom);
        check("read_busy", busy, 1);
        check("read_ready", instr_ready, 0);
        check("read_rr1", readReg1, rs);
        check("read_rr2", readReg2, rt);
        check("read_we", RegWrite, 0);
        @(negedge clk);
        check("exec_we", RegWrite, 0);
        check("exec_busy", busy, 1);
        @(negedge clk);
        we_a = RegWrite; wr_a = WriteReg; wd_a = WriteData;
        check("wb_we", RegWrite, exp_we);
        if (exp_we) begin
            check("wb_wr", WriteReg, rd);
            check("wb_wd", WriteData, exp_wd);
        end
        check("wb_rr1", readReg1, rs);
        check("wb_ill", illegal_op, model_ill || (op >= 4'd7));
        if (exp_we) model_rf[rd] = exp_wd;
        if (op >= 4'd7) model_ill = 1'b1;
        model_cnt = model_cnt + 1'b1;
        @(negedge clk);
        check("idle_ready", instr_ready, 1);
        check("idle_cnt", retired_count, model_cnt);
        check("idle_ill", illegal_op, model_ill);
    endtask

    typedef struct {
        logic [15:0] w;
        logic        we;
        logic [1:0]  wr;
        logic [31:0] wd;
        logic        ill;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic        we_a;
        logic [1:0]  wr_a;
        logic [31:0] wd_a;
        int          t0;

        tbl[0] = '{16'h5405, 1'b1, 2'd1, 32'd5,          1'b0}; // LI r1,5
        tbl[1] = '{16'h5803, 1'b1, 2'd2, 32'd3,          1'b0}; // LI r2,3
        tbl[2] = '{16'h1180, 1'b1, 2'd0, 32'd8,          1'b0}; // ADD r0,r1,r2
        tbl[3] = '{16'h2E40, 1'b1, 2'd3, 32'hFFFF_FFFE,  1'b0}; // SUB r3,r2,r1
        tbl[4] = '{16'h6E40, 1'b1, 2'd3, 32'd1,          1'b0}; // SLT r3,r2,r1
        tbl[5] = '{16'h6D80, 1'b1, 2'd3, 32'd0,          1'b0}; // SLT r3,r1,r2
        tbl[6] = '{16'h3180, 1'b1, 2'd0, 32'd1,          1'b0}; // AND r0,r1,r2
        tbl[7] = '{16'h4180, 1'b1, 2'd0, 32'd7,          1'b0}; // OR  r0,r1,r2
        tbl[8] = '{16'h9000, 1'b0, 2'd0, 32'd0,          1'b1}; // illegal op 9
        tbl[9] = '{16'h0000, 1'b0, 2'd0, 32'd0,          1'b1}; // NOP

        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'd0;
        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 10; i++) begin
            do_instr(tbl[i].w, 1'b0, 16'd0, we_a, wr_a, wd_a);
            check("tbl_we", we_a, tbl[i].we);
            if (tbl[i].we) begin
                check("tbl_wr", wr_a, tbl[i].wr);
                check("tbl_wd", wd_a, tbl[i].wd);
            end
            check("tbl_ill", illegal_op, tbl[i].ill);
            check("tbl_cnt", retired_count, i + 1);
            $display("vec %0d instr=%h we=%b wr=%0d wd=%h cnt=%0d", i, tbl[i].w, we_a, wr_a, wd_a, retired_count);
        end

        // Back-to-back with instr_valid held: LI r1,7 then ADD r2,r1,r1.
        do_instr(16'h5407, 1'b1, 16'h1940, we_a, wr_a, wd_a);
        t0 = hs_cyc_last;
        do_instr(16'h1940, 1'b0, 16'd0, we_a, wr_a, wd_a);
        check("b2b_gap", hs_cyc_last - t0, 4);
        check("b2b_wd", wd_a, 14);
        check("b2b_wr", wr_a, 2);
        $display("b2b gap=%0d wd=%0d", hs_cyc_last - t0, wd_a);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] w, nx;
            w  = {4'($urandom_range(0, 15)), 12'($urandom)};
            nx = 16'($urandom);
            do_instr(w, 1'($urandom), nx, we_a, wr_a, wd_a);
            $display("rnd %0d instr=%h we=%b wr=%0d wd=%h", i, w, we_a, wr_a, wd_a);
        end

        // Reset during WB of ADD r2,r1,r1.
        instr = 16'h1940;
        instr_valid = 1'b1;
        for (int n = 0; n < 8 && !instr_ready; n++) @(negedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_wb_we_before", RegWrite, 1);
        reset = 1'b1;
        #1;
        check("abort_wb_we_in_reset", RegWrite, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check_reset_outputs("abort");
        $display("reset-in-WB abort busy=%b cnt=%0d", busy, retired_count);

        // Handshake coincident with reset is dropped.
        instr = 16'h5BFF;
        instr_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0;
        check("rst_hs_busy", busy, 0);
        check("rst_hs_ready", instr_ready, 1);
        @(negedge clk);
        check("rst_hs_busy2", busy, 0);
        check("rst_hs_we", RegWrite, 0);
        $display("reset+handshake busy=%b", busy);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) - 1; i++) do_instr(16'h0000, 1'b0, 16'd0, we_a, wr_a, wd_a);
        check("wrap_max", retired_count, (1 << CNT_W) - 1);
        do_instr(16'h5405, 1'b0, 16'd0, we_a, wr_a, wd_a);
        check("wrap_zero", retired_count, 0);
        $display("wrap cnt=%0d", retired_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of retired_count.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: instr_valid  input  1  upstream instruction valid.
REQ-006 Port: instr  input  16  instruction word: op[15:12], rd[11:10], rs[9:8], rt[7:6], imm8[7:0].
REQ-007 Port: instr_ready  output  1  block can accept an instruction.
REQ-008 Port: readReg1  output  2  register-file read address 1.
REQ-009 Port: readReg2  output  2  register-file read address 2.
REQ-010 Port: ReadData1  input  32  register-file combinational read data 1.
REQ-011 Port: ReadData2  input  32  register-file combinational read data 2.
REQ-012 Port: WriteReg  output  2  register-file write address.
REQ-013 Port: WriteData  output  32  register-file write data.
REQ-014 Port: RegWrite  output  1  register-file write enable.
REQ-015 Port: busy  output  1  instruction in flight (state != IDLE).
REQ-016 Port: illegal_op  output  1  sticky flag, unrecognised opcode seen.
REQ-017 Port: retired_count  output  CNT_W  instructions completed.

Function
REQ-018 The FSM SHALL have states IDLE, READ, EXEC, WB; IDLE->READ on handshake, READ->EXEC, EXEC->WB, WB->IDLE, each unconditional after one cycle.
REQ-019 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid && instr_ready, capturing instr into an internal register at that edge.
REQ-020 readReg1/readReg2 SHALL be registered copies of captured rs/rt, stable from READ through WB.
REQ-021 At the end of READ, ReadData1/ReadData2 SHALL be latched into operand registers A/B.
REQ-022 At the end of EXEC, the result register SHALL be loaded per opcode: 0 NOP; 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 LI zero-extended imm8; 6 SLT signed (A<B ? 1 : 0); 7-15 illegal.
REQ-023 ADD/SUB SHALL wrap modulo 2^32, no carry/overflow output.
REQ-024 RegWrite SHALL be (state==WB) && !reset && opcode in 1..6; WriteReg=rd and WriteData=result held stable throughout WB.
REQ-025 NOP and illegal opcodes SHALL traverse all four states with RegWrite=0 in WB.
REQ-026 illegal_op SHALL set at the EXEC->WB edge for opcodes 7-15 and stay set until reset.
REQ-027 retired_count SHALL increment by 1 at every WB->IDLE edge (all opcodes), wrapping from 2^CNT_W-1 to 0.
REQ-028 Latency: handshake at edge N, RegWrite high during cycle N+3; throughput one instruction per 4 cycles.
REQ-029 A back-to-back instruction reading the previous rd SHALL see the newly written value (write commits at WB edge, before next READ).
REQ-030 instr_valid while not in IDLE SHALL be ignored; upstream holds instr until handshake.
REQ-031 rs/rt equal to rd, or rs equal to rt, SHALL require no special handling.

Reset
REQ-032 On a clock edge with reset=1: state=IDLE, captured instr=0, A=B=result=0, readReg1=readReg2=0, illegal_op=0, retired_count=0.
REQ-033 After reset: instr_ready=1, busy=0, RegWrite=0, WriteReg=0, WriteData=0.
REQ-034 Reset asserted in any state SHALL abort the in-flight instruction; RegWrite SHALL be 0 in any cycle where reset=1, including WB.
REQ-035 A handshake in the same cycle as reset SHALL be discarded.

Verification
REQ-036 Reset, then LI r1,5; LI r2,3 -> RegWrite pulses with (WriteReg,WriteData)=(1,5) then (2,3); retired_count=2.
REQ-037 With r1=5, r2=3: ADD r0,r1,r2 -> WriteData 8; SUB r3,r2,r1 -> WriteData 0xFFFFFFFE; SLT r3,r2,r1 (3<5) -> 1.
REQ-038 Back-to-back LI r1,7 then ADD r2,r1,r1 with instr_valid held -> second handshake exactly 4 cycles after first; r2 written 14.
REQ-039 Opcode 9 then NOP -> no RegWrite for either, illegal_op=1 from WB of the first, retired_count +2.
REQ-040 Reset asserted during WB of ADD -> RegWrite stays 0, next cycle IDLE, all outputs at reset values.
REQ-041 Force retired_count to 0xFFFF (CNT_W=16) via 65535 NOPs, one more instruction -> retired_count=0.
